// File: rtl/bus_dma_host_pkg.sv
// Shared types and constants for the bus_dma_host copy engine.
package bus_dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } dma_state_e;

  // Byte offsets of the register window (only bits [4:2] are decoded)
  localparam logic [4:0] RegSrc    = 5'h00;
  localparam logic [4:0] RegDst    = 5'h04;
  localparam logic [4:0] RegLen    = 5'h08;
  localparam logic [4:0] RegCtrl   = 5'h0C;
  localparam logic [4:0] RegStatus = 5'h10;

  localparam int CtrlStartBit   = 0;
  localparam int CtrlIrqEnBit   = 1;
  localparam int StatusBusyBit  = 0;
  localparam int StatusDoneBit  = 1;
  localparam int StatusErrorBit = 2;

  // Offsets 0x14..0x1C are holes in the window and answer with an error
  function automatic logic is_unmapped(input logic [4:0] off);
    return off[4:2] > 3'd4;
  endfunction

endpackage

// File: rtl/bus_dma_host_if.sv
// Device-side register port and host-side initiator port of the copy engine.
interface bus_dma_host_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic                    dev_req_i;
  logic                    dev_we_i;
  logic [3:0]              dev_be_i;
  logic [AddressWidth-1:0] dev_addr_i;
  logic [DataWidth-1:0]    dev_wdata_i;
  logic                    dev_rvalid_o;
  logic [DataWidth-1:0]    dev_rdata_o;
  logic                    dev_err_o;

  logic                    host_req_o;
  logic                    host_gnt_i;
  logic [AddressWidth-1:0] host_addr_o;
  logic                    host_we_o;
  logic [3:0]              host_be_o;
  logic [DataWidth-1:0]    host_wdata_o;
  logic                    host_rvalid_i;
  logic [DataWidth-1:0]    host_rdata_i;
  logic                    host_err_i;

  // The DMA engine side
  modport master (
    input  dev_req_i, dev_we_i, dev_be_i, dev_addr_i, dev_wdata_i,
    output dev_rvalid_o, dev_rdata_o, dev_err_o,
    output host_req_o, host_addr_o, host_we_o, host_be_o, host_wdata_o,
    input  host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i
  );

  // The system side: core data port driving registers, memory answering the host port
  modport slave (
    output dev_req_i, dev_we_i, dev_be_i, dev_addr_i, dev_wdata_i,
    input  dev_rvalid_o, dev_rdata_o, dev_err_o,
    input  host_req_o, host_addr_o, host_we_o, host_be_o, host_wdata_o,
    output host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i
  );

endinterface

// File: rtl/bus_dma_host_regs.sv
// Register file of the copy engine plus the one-cycle device response path.
module bus_dma_regs
  import bus_dma_pkg::*;
#(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [3:0]              i_be,
  input  logic [AddressWidth-1:0] i_addr,
  input  logic [DataWidth-1:0]    i_wdata,
  output logic                    o_rvalid,
  output logic [DataWidth-1:0]    o_rdata,
  output logic                    o_err,
  input  logic                    i_busy,
  input  logic                    i_done_set,
  input  logic                    i_err_set,
  output logic                    o_start,
  output logic [AddressWidth-1:0] o_src,
  output logic [AddressWidth-1:0] o_dst,
  output logic [LenWidth-1:0]     o_len,
  output logic                    o_irq_en,
  output logic                    o_done,
  output logic                    o_error
);

  logic [AddressWidth-1:0] r_src;
  logic [AddressWidth-1:0] r_dst;
  logic [LenWidth-1:0]     r_len;
  logic                    r_irq_en;
  logic                    r_done;
  logic                    r_error;
  logic                    r_rvalid;
  logic [DataWidth-1:0]    r_rdata;
  logic                    r_err;

  logic [4:0]              w_off;
  logic                    w_wr;
  logic [DataWidth-1:0]    w_rd_data;
  logic                    w_unused_addr;

  assign w_off         = {i_addr[4:2], 2'b00};
  assign w_wr          = i_req & i_we & (i_be == 4'hF);
  assign w_unused_addr = ^{i_addr[AddressWidth-1:5], i_addr[1:0]};
  assign o_start       = w_wr & (w_off == RegCtrl) & i_wdata[CtrlStartBit] & ~i_busy;

  // Software-visible registers; transfer setup is frozen while a copy runs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr && !i_busy) begin
        if (w_off == RegSrc) r_src <= {i_wdata[AddressWidth-1:2], 2'b00};
        if (w_off == RegDst) r_dst <= {i_wdata[AddressWidth-1:2], 2'b00};
        if (w_off == RegLen) r_len <= i_wdata[LenWidth-1:0];
      end
      if (w_wr && w_off == RegCtrl) r_irq_en <= i_wdata[CtrlIrqEnBit];
      // A hardware set beats a software clear landing in the same cycle
      if (i_done_set)
        r_done <= 1'b1;
      else if (o_start || (w_wr && w_off == RegStatus && i_wdata[StatusDoneBit]))
        r_done <= 1'b0;
      if (i_err_set)
        r_error <= 1'b1;
      else if (o_start || (w_wr && w_off == RegStatus && i_wdata[StatusErrorBit]))
        r_error <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    w_rd_data = '0;
    case (w_off)
      RegSrc:    w_rd_data = DataWidth'(r_src);
      RegDst:    w_rd_data = DataWidth'(r_dst);
      RegLen:    w_rd_data = DataWidth'(r_len);
      RegCtrl:   w_rd_data[CtrlIrqEnBit] = r_irq_en;
      RegStatus: begin
        w_rd_data[StatusBusyBit]  = i_busy;
        w_rd_data[StatusDoneBit]  = r_done;
        w_rd_data[StatusErrorBit] = r_error;
      end
      default:   w_rd_data = '0;
    endcase
  end

  // Every request is answered exactly one cycle later; writes return zero data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= i_req;
      r_err    <= i_req & is_unmapped(w_off);
      r_rdata  <= (i_req && !i_we) ? w_rd_data : '0;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;
  assign o_src    = r_src;
  assign o_dst    = r_dst;
  assign o_len    = r_len;
  assign o_irq_en = r_irq_en;
  assign o_done   = r_done;
  assign o_error  = r_error;

endmodule

// File: rtl/bus_dma_host.sv
// Memory-to-memory word copy engine: register window on the device port,
// one outstanding read/write at a time on the host port.
//
// state   | meaning
// IDLE    | no transfer; waiting for START
// RD_REQ  | read of cur_src requested, waiting for grant
// RD_WAIT | read granted, waiting for response data
// WR_REQ  | write of buffer to cur_dst requested, waiting for grant
// WR_WAIT | write granted, waiting for response; then advance or finish
module bus_dma_host
  import bus_dma_pkg::*;
#(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bus_dma_host_if.master bus,
  output logic          irq_o
);

  dma_state_e              r_state;
  logic                    r_req;
  logic                    r_we;
  logic [3:0]              r_be;
  logic [AddressWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_wdata;
  logic [AddressWidth-1:0] r_cur_src;
  logic [AddressWidth-1:0] r_cur_dst;
  logic [LenWidth-1:0]     r_rem;
  logic                    r_zero_pend;

  logic                    w_start;
  logic [AddressWidth-1:0] w_src;
  logic [AddressWidth-1:0] w_dst;
  logic [LenWidth-1:0]     w_len;
  logic                    w_irq_en;
  logic                    w_done;
  logic                    w_error;
  logic                    w_busy;
  logic                    w_abort;
  logic                    w_last;
  logic                    w_done_set;

  bus_dma_regs #(
    .AddressWidth (AddressWidth),
    .DataWidth    (DataWidth),
    .LenWidth     (LenWidth)
  ) u_regs (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_req      (bus.dev_req_i),
    .i_we       (bus.dev_we_i),
    .i_be       (bus.dev_be_i),
    .i_addr     (bus.dev_addr_i),
    .i_wdata    (bus.dev_wdata_i),
    .o_rvalid   (bus.dev_rvalid_o),
    .o_rdata    (bus.dev_rdata_o),
    .o_err      (bus.dev_err_o),
    .i_busy     (w_busy),
    .i_done_set (w_done_set),
    .i_err_set  (w_abort),
    .o_start    (w_start),
    .o_src      (w_src),
    .o_dst      (w_dst),
    .o_len      (w_len),
    .o_irq_en   (w_irq_en),
    .o_done     (w_done),
    .o_error    (w_error)
  );

  // A zero-length START keeps BUSY up for the single cycle before DONE appears
  assign w_busy     = (r_state != IDLE) | r_zero_pend;
  assign w_abort    = bus.host_rvalid_i & bus.host_err_i &
                      ((r_state == RD_WAIT) | (r_state == WR_WAIT));
  assign w_last     = (r_state == WR_WAIT) & bus.host_rvalid_i & ~bus.host_err_i &
                      (r_rem == LenWidth'(1));
  assign w_done_set = w_abort | w_last | r_zero_pend;

  // Transfer sequencer with registered bus outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'h0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cur_src   <= '0;
      r_cur_dst   <= '0;
      r_rem       <= '0;
      r_zero_pend <= 1'b0;
    end else begin
      r_be        <= 4'hF;
      r_zero_pend <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cur_src <= w_src;
            r_cur_dst <= w_dst;
            r_rem     <= w_len;
            if (w_len == '0) begin
              r_zero_pend <= 1'b1;
            end else begin
              r_state <= RD_REQ;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= w_src;
            end
          end
        end
        RD_REQ: begin
          if (bus.host_gnt_i) begin
            r_state <= RD_WAIT;
            r_req   <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (bus.host_rvalid_i) begin
            if (bus.host_err_i) begin
              r_state <= IDLE;
            end else begin
              r_wdata <= bus.host_rdata_i;
              r_state <= WR_REQ;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= r_cur_dst;
            end
          end
        end
        WR_REQ: begin
          if (bus.host_gnt_i) begin
            r_state <= WR_WAIT;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (bus.host_rvalid_i) begin
            r_cur_src <= r_cur_src + AddressWidth'(4);
            r_cur_dst <= r_cur_dst + AddressWidth'(4);
            r_rem     <= r_rem - LenWidth'(1);
            if (bus.host_err_i || r_rem == LenWidth'(1)) begin
              r_state <= IDLE;
            end else begin
              r_state <= RD_REQ;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= r_cur_src + AddressWidth'(4);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.host_req_o   = r_req;
  assign bus.host_we_o    = r_we;
  assign bus.host_be_o    = r_be;
  assign bus.host_addr_o  = r_addr;
  assign bus.host_wdata_o = r_wdata;

  assign irq_o = w_done & w_irq_en;

endmodule

// File: tb/tb_bus_dma_host.sv
// Randomized scoreboard bench for bus_dma_host: a memory responder checks
// every granted host transaction against a queue of expected accesses and a
// device monitor checks every register response against a queue of expected reads.
module tb_bus_dma_host;
  import bus_dma_pkg::*;

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] data;
  } bus_txn_t;

  typedef struct {
    bit        chk_data;
    bit [31:0] data;
    bit        err;
  } dev_rsp_t;

  logic clk;
  logic rst;
  logic irq;

  bus_dma_host_if #(.AddressWidth(32), .DataWidth(32)) bus ();

  bus_dma_host #(.AddressWidth(32), .DataWidth(32), .LenWidth(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master),
    .irq_o (irq)
  );

  int checks = 0;
  int errors = 0;

  bus_txn_t  exp_bus[$];
  dev_rsp_t  exp_dev[$];
  bit [31:0] mem[bit [31:0]];
  bit [31:0] src_vals[$];

  int        gnt_hold   = 0;
  bit        rand_hold  = 0;
  int        err_rd_idx = -1;
  int        rd_count   = 0;
  bit        rsp_pend   = 0;
  bit [31:0] rsp_data;
  bit        rsp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic bit [31:0] sentinel(input bit [31:0] dst, input int i);
    return 32'hA5A5_0000 ^ dst[15:0] ^ 32'(i);
  endfunction

  // Memory responder on the host port: grants, scoreboards, answers one cycle later
  always @(negedge clk) begin : p_resp
    bus_txn_t e;
    if (rst) begin
      bus.host_gnt_i    = 1'b0;
      bus.host_rvalid_i = 1'b0;
      bus.host_err_i    = 1'b0;
      bus.host_rdata_i  = 32'h0;
      rsp_pend          = 1'b0;
    end else begin
      bus.host_rvalid_i = 1'b0;
      bus.host_err_i    = 1'b0;
      if (rsp_pend) begin
        bus.host_rvalid_i = 1'b1;
        bus.host_rdata_i  = rsp_data;
        bus.host_err_i    = rsp_err;
        rsp_pend          = 1'b0;
      end
      bus.host_gnt_i = 1'b0;
      if (bus.host_req_o) begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected_req", bus.host_addr_o, 32'hFFFF_FFFF);
        end else if (gnt_hold > 0) begin
          chk("hold_addr", bus.host_addr_o, exp_bus[0].addr);
          chk("hold_we", 32'(bus.host_we_o), 32'(exp_bus[0].we));
          gnt_hold--;
        end else begin
          bus.host_gnt_i = 1'b1;
          e = exp_bus.pop_front();
          chk("bus_we", 32'(bus.host_we_o), 32'(e.we));
          chk("bus_addr", bus.host_addr_o, e.addr);
          chk("bus_be", 32'(bus.host_be_o), 32'hF);
          if (e.we) begin
            chk("bus_wdata", bus.host_wdata_o, e.data);
            mem[bus.host_addr_o] = bus.host_wdata_o;
            rsp_data = 32'h0;
            rsp_err  = 1'b0;
          end else begin
            rsp_data = mem_rd(bus.host_addr_o);
            rsp_err  = (rd_count == err_rd_idx);
            rd_count++;
          end
          rsp_pend = 1'b1;
          if (rand_hold) gnt_hold = $urandom_range(0, 2);
        end
      end
    end
  end

  // Device response monitor
  always @(negedge clk) begin : p_dev_mon
    dev_rsp_t r;
    if (!rst && bus.dev_rvalid_o) begin
      if (exp_dev.size() == 0) begin
        chk("dev_unexpected_rvalid", 32'h1, 32'h0);
      end else begin
        r = exp_dev.pop_front();
        chk("dev_err", 32'(bus.dev_err_o), 32'(r.err));
        if (r.chk_data) chk("dev_rdata", bus.dev_rdata_o, r.data);
      end
    end
  end

  task automatic dev_access(input bit we, input bit [4:0] off, input bit [31:0] wdata,
                            input bit chk_data, input bit [31:0] exp_data);
    dev_rsp_t r;
    r.chk_data = chk_data;
    r.data     = exp_data;
    r.err      = (off[4:2] > 3'd4);
    exp_dev.push_back(r);
    @(posedge clk); #1;
    bus.dev_req_i   = 1'b1;
    bus.dev_we_i    = we;
    bus.dev_be_i    = 4'hF;
    bus.dev_addr_i  = {$urandom_range(0, 255) << 8} | 32'(off);
    bus.dev_wdata_i = wdata;
    @(posedge clk); #1;
    bus.dev_req_i   = 1'b0;
    bus.dev_we_i    = 1'b0;
  endtask

  task automatic dev_write(input bit [4:0] off, input bit [31:0] wdata);
    dev_access(1'b1, off, wdata, 1'b0, 32'h0);
  endtask

  task automatic dev_read(input bit [4:0] off, input bit [31:0] exp);
    dev_access(1'b0, off, 32'h0, 1'b1, exp);
  endtask

  task automatic wait_bus_idle();
    int n = 0;
    while ((exp_bus.size() != 0 || rsp_pend) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) chk("bus_timeout", 32'(exp_bus.size()), 32'h0);
    repeat (3) @(posedge clk);
  endtask

  // Reference model: the transfer is LEN read/write pairs at ascending word
  // addresses; an erroring read ends it before its write
  task automatic xfer_prep(input bit [31:0] src, input bit [31:0] dst,
                           input int len, input int err_idx);
    bus_txn_t t;
    int nrd;
    src_vals.delete();
    for (int i = 0; i < len; i++) begin
      src_vals.push_back($urandom);
      mem[src + 32'(4 * i)] = src_vals[i];
      mem[dst + 32'(4 * i)] = sentinel(dst, i);
    end
    err_rd_idx = err_idx;
    rd_count   = 0;
    nrd = (err_idx >= 0 && err_idx < len) ? err_idx + 1 : len;
    for (int i = 0; i < nrd; i++) begin
      t.we = 1'b0; t.addr = src + 32'(4 * i); t.data = 32'h0;
      exp_bus.push_back(t);
      if (i != err_idx) begin
        t.we = 1'b1; t.addr = dst + 32'(4 * i); t.data = src_vals[i];
        exp_bus.push_back(t);
      end
    end
  endtask

  task automatic xfer_program(input bit [31:0] src, input bit [31:0] dst,
                              input int len, input bit ien);
    bit [31:0] junk;
    junk = $urandom;
    dev_write(RegSrc, src | 32'(junk[1:0]));
    dev_write(RegDst, dst | 32'(junk[3:2]));
    dev_write(RegLen, 32'(len));
    dev_write(RegCtrl, {30'h0, ien, 1'b1});
  endtask

  task automatic xfer_finish(input bit [31:0] dst, input int len,
                             input int err_idx, input bit ien);
    bit written;
    wait_bus_idle();
    for (int i = 0; i < len; i++) begin
      written = (err_idx < 0) ? 1'b1 : (i < err_idx);
      chk("dst_word", mem_rd(dst + 32'(4 * i)),
          written ? src_vals[i] : sentinel(dst, i));
    end
    dev_read(RegStatus, (err_idx >= 0) ? 32'h6 : 32'h2);
    chk("irq_after_xfer", 32'(irq), 32'(ien));
  endtask

  task automatic run_xfer(input bit [31:0] src, input bit [31:0] dst, input int len,
                          input int err_idx, input bit ien);
    xfer_prep(src, dst, len, err_idx);
    xfer_program(src, dst, len, ien);
    xfer_finish(dst, len, err_idx, ien);
  endtask

  initial begin : p_watchdog
    #3_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    bit [31:0] s, d;
    int        l;
    bit        ien;
    rst             = 1'b1;
    bus.dev_req_i   = 1'b0;
    bus.dev_we_i    = 1'b0;
    bus.dev_be_i    = 4'h0;
    bus.dev_addr_i  = 32'h0;
    bus.dev_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_host_req", 32'(bus.host_req_o), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_dev_rvalid", 32'(bus.dev_rvalid_o), 32'h0);
    rst = 1'b0;

    // Reset values of the whole window, plus one hole
    dev_read(RegSrc, 32'h0);
    dev_read(RegDst, 32'h0);
    dev_read(RegLen, 32'h0);
    dev_read(RegCtrl, 32'h0);
    dev_read(RegStatus, 32'h0);
    dev_read(5'h14, 32'h0);

    // LEN upper bits ignored; non-word-aligned SRC is forced aligned
    dev_write(RegLen, 32'hABCD_0004);
    dev_read(RegLen, 32'h4);
    dev_write(RegSrc, 32'h1234_5677);
    dev_read(RegSrc, 32'h1234_5674);
    dev_write(RegCtrl, 32'h2);
    dev_read(RegCtrl, 32'h2);

    // Basic 4-word copy
    run_xfer(32'h0010_0000, 32'h0010_0400, 4, -1, 1'b1);

    // First read grant withheld three cycles
    gnt_hold = 3;
    run_xfer(32'h0010_0800, 32'h0010_0C00, 3, -1, 1'b1);

    // Bus error on the second read
    run_xfer(32'h0010_1000, 32'h0010_1400, 4, 1, 1'b1);
    chk("err_dst4_untouched", mem_rd(32'h0010_1404), sentinel(32'h0010_1400, 1));
    dev_write(RegStatus, 32'h6);
    dev_read(RegStatus, 32'h0);
    @(negedge clk);
    chk("irq_after_w1c", 32'(irq), 32'h0);

    // Zero-length transfer: no bus traffic, DONE follows one cycle after START
    dev_write(RegStatus, 32'h0);
    dev_write(RegLen, 32'h0);
    dev_write(RegCtrl, 32'h3);
    @(negedge clk);
    chk("len0_irq_first_cycle", 32'(irq), 32'h0);
    @(negedge clk);
    chk("len0_irq_second_cycle", 32'(irq), 32'h1);
    dev_read(RegStatus, 32'h2);

    // Register writes and START while busy are ignored
    rand_hold = 1'b1;
    xfer_prep(32'h0020_0000, 32'h0020_0800, 6, -1);
    xfer_program(32'h0020_0000, 32'h0020_0800, 6, 1'b1);
    dev_read(RegStatus, 32'h1);
    dev_write(RegSrc, 32'hDEAD_0000);
    dev_write(RegCtrl, 32'h3);
    dev_write(RegLen, 32'h9);
    dev_read(RegSrc, 32'h0020_0000);
    dev_read(RegLen, 32'h6);
    xfer_finish(32'h0020_0800, 6, -1, 1'b1);
    dev_read(5'h18, 32'h0);
    dev_write(5'h1C, 32'hFFFF_FFFF);

    // Address wrap-around on the source side
    run_xfer(32'hFFFF_FFF8, 32'h4000_0000, 4, -1, 1'b0);

    // Randomized transfers, some with late-read errors
    for (int k = 0; k < 5; k++) begin
      s   = 32'h2000_0000 + 32'(k) * 32'h1000 + ($urandom_range(0, 63) << 2);
      d   = 32'h3000_0000 + 32'(k) * 32'h1000 + ($urandom_range(0, 63) << 2);
      l   = $urandom_range(1, 8);
      ien = 1'($urandom_range(0, 1));
      run_xfer(s, d, l, ($urandom_range(0, 3) == 0) ? $urandom_range(0, l - 1) : -1, ien);
    end

    repeat (5) @(posedge clk);
    chk("dev_queue_drained", 32'(exp_dev.size()), 32'h0);
    chk("bus_queue_drained", 32'(exp_bus.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_dma_host.md
Name: bus_dma_host

Overview:
- Register-programmed memory-to-memory copy engine for the simple system.
- Acts as a second bus initiator, alongside the core data port, using the req/gnt/rvalid host protocol.
- Exposes a small device-side register window so software on the core can program and monitor transfers.
- Copies LEN 32-bit words from SRC to DST, then raises a done interrupt.

Parameters:
- AddressWidth, 32, width of bus addresses (host and device side).
- DataWidth, 32, width of bus data; must be 32.
- LenWidth, 16, width of the LEN register (max words per transfer = 2^LenWidth-1).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- dev_req_i  in  1  register access request (always accepted; no gnt)
- dev_we_i  in  1  register write enable
- dev_be_i  in  4  byte enables; a register write requires 4'hF, otherwise it is ignored
- dev_addr_i  in  AddressWidth  register address; only bits [4:2] are decoded
- dev_wdata_i  in  DataWidth  register write data
- dev_rvalid_o  out  1  response valid, exactly 1 cycle after dev_req_i
- dev_rdata_o  out  DataWidth  register read data
- dev_err_o  out  1  error response for an unmapped offset, valid with dev_rvalid_o
- host_req_o  out  1  bus request
- host_gnt_i  in  1  bus grant
- host_addr_o  out  AddressWidth  bus address, word aligned ([1:0]=0)
- host_we_o  out  1  bus write enable
- host_be_o  out  4  bus byte enables, always 4'hF
- host_wdata_o  out  DataWidth  bus write data
- host_rvalid_i  in  1  bus response valid
- host_rdata_i  in  DataWidth  bus read data
- host_err_i  in  1  bus error, valid with host_rvalid_i
- irq_o  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Reset values: all outputs 0; registers SRC, DST, LEN, IRQ_EN, DONE, ERROR all 0; FSM in IDLE.
- Register map (word offsets):
  - 0x00 SRC, read/write.
  - 0x04 DST, read/write.
  - 0x08 LEN, read/write; upper bits read 0.
  - 0x0C CTRL: bit0 START (write-only, reads 0), bit1 IRQ_EN (read/write).
  - 0x10 STATUS: bit0 BUSY (read-only), bit1 DONE (write 1 to clear), bit2 ERROR (write 1 to clear).
  - Offsets 0x14–0x1C: read data 0, dev_err_o=1, writes have no effect.
- SRC and DST bits [1:0] are forced to 0 on write.
- Writes to SRC, DST or LEN while BUSY are ignored. START while BUSY is ignored. IRQ_EN is writable at any time.
- START when idle:
  - Copies SRC, DST and LEN into working counters.
  - Clears DONE and ERROR, sets BUSY on the next cycle.
  - If LEN=0: DONE is set in the next cycle and no bus traffic occurs.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - IDLE -> RD_REQ on START with LEN≠0.
  - RD_REQ: host_req_o=1, we=0, addr=cur_src. Stay until host_gnt_i; grant may be combinational, same cycle. Address is held stable while ungranted. Then go to RD_WAIT.
  - RD_WAIT: host_req_o=0. On host_rvalid_i, latch rdata into the data buffer and go to WR_REQ. If host_err_i, go to IDLE with ERROR=1, DONE=1, BUSY=0.
  - WR_REQ: host_req_o=1, we=1, addr=cur_dst, wdata=buffer. On gnt go to WR_WAIT.
  - WR_WAIT: on host_rvalid_i, cur_src+=4, cur_dst+=4, remaining-=1.
    - If error: abort as above.
    - Else if remaining becomes 0: go to IDLE, DONE=1, BUSY=0.
    - Else go to RD_REQ.
- At most one outstanding bus transaction. rvalid arriving in the same cycle as gnt is not expected (responder latency ≥1); rvalid in any REQ state is ignored.
- Address arithmetic is modulo 2^AddressWidth; wrap-around is silent.
- A software write-1-to-clear of DONE in the same cycle the FSM sets DONE: set wins.
- irq_o is combinational from registered DONE and IRQ_EN.
- Reset mid-transfer: all state cleared immediately, host_req_o drops asynchronously, and any in-flight response is discarded after reset.

Decomposition:
- Package bus_dma_pkg holds:
  - dma_state_e enum;
  - register offset localparams: RegSrc, RegDst, RegLen, RegCtrl, RegStatus;
  - STATUS/CTRL bit index constants.
- One sub-module, bus_dma_regs: register file plus device-port response logic, including the dev_rvalid_o pipeline flop. The FSM lives in the top level.

Test Plan:
1. Reset, then read all registers -> all read 0; irq_o=0; host_req_o=0.
2. SRC=0x100000, DST=0x100400, LEN=4, CTRL=0x3 with a 1-cycle-latency RAM model:
   - exactly 4 reads (0x100000..0x10000C) and 4 writes (0x100400..0x10040C);
   - destination contents equal source contents;
   - STATUS=0x2 and irq_o=1 afterwards.
3. Grant withheld 3 cycles on the first read -> host_addr_o and host_req_o stay stable for all 3 cycles; the transfer completes correctly.
4. host_err_i asserted on the 2nd read -> no further requests; STATUS=0x6; DST+0 written, DST+4 untouched.
5. LEN=0 with START -> no host_req_o; DONE=1 two cycles after the START write.
6. Write SRC and START while BUSY -> SRC readback unchanged and the transfer is unaffected. Read offset 0x18 -> dev_err_o=1, rdata=0.
